exe_alu_unit: RTL and testbench

Execute-stage arithmetic block for the RV32I core. It selects ALU operands from register, PC, immediate or constant sources using keyed multiplexers with a default. It computes one of ten integer operations and resolves conditional-branch requests from compare flags. Results are registered, giving one cycle of latency between decode/operand fetch and the memory/writeback path.

---
 rtl/exe_alu_unit.sv | 142 ++++++++++++++
 tb/tb_exe_alu_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_alu_unit.sv
// Execute-stage ALU for the RV32I core.
// Picks operands from register/PC/immediate/constant sources, computes one of
// ten integer operations, resolves conditional branches from the compare flags
// and registers everything for a single cycle of latency.
module exe_alu_unit #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATA_LEN-1:0] reg1_i,
    input  logic [DATA_LEN-1:0] reg2_i,
    input  logic [DATA_LEN-1:0] pc_i,
    input  logic [DATA_LEN-1:0] imm_i,
    input  logic [3:0]          alu_control,
    input  logic [3:0]          alu_sel,
    input  logic [2:0]          branch_type_i,
    output logic                out_valid,
    output logic [DATA_LEN-1:0] alu_result_o,
    output logic                alu_zero_o,
    output logic                alu_less_o,
    output logic                branch_request_o
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGE  = 3'b100;
    localparam logic [2:0] BR_BLTU = 3'b101;
    localparam logic [2:0] BR_BGEU = 3'b110;

    logic        [DATA_LEN-1:0] src1_p0;
    logic        [DATA_LEN-1:0] src2_p0;
    logic signed [DATA_LEN-1:0] src1_s_p0;
    logic signed [DATA_LEN-1:0] src2_s_p0;
    logic signed [DATA_LEN-1:0] sra_s_p0;
    logic        [4:0]          shamt_p0;
    logic        [DATA_LEN-1:0] result_p0;
    logic                       less_p0;
    logic                       zero_p0;
    logic                       branch_p0;

    logic                       vld_p1;
    logic        [DATA_LEN-1:0] result_p1;
    logic                       zero_p1;
    logic                       less_p1;
    logic                       branch_p1;

    // Operand muxes: unmatched keys fall back to zero.
    always_comb begin
        src1_p0 = '0;
        src2_p0 = '0;
        case (alu_sel[1:0])
            2'b01:   src1_p0 = reg1_i;
            2'b10:   src1_p0 = pc_i;
            default: src1_p0 = '0;
        endcase
        case (alu_sel[3:2])
            2'b01:   src2_p0 = reg2_i;
            2'b10:   src2_p0 = imm_i;
            2'b11:   src2_p0 = DATA_LEN'(4);
            default: src2_p0 = '0;
        endcase
    end

    // Operation, compare flags and branch decision for the current operands.
    always_comb begin
        src1_s_p0 = src1_p0;
        src2_s_p0 = src2_p0;
        shamt_p0  = src2_p0[4:0];
        sra_s_p0  = src1_s_p0 >>> shamt_p0;
        // SLTU is the only unsigned compare; every other code compares signed.
        if (alu_control == OP_SLTU) begin
            less_p0 = src1_p0 < src2_p0;
        end else begin
            less_p0 = src1_s_p0 < src2_s_p0;
        end
        case (alu_control)
            OP_ADD:  result_p0 = src1_p0 + src2_p0;
            OP_SUB:  result_p0 = src1_p0 - src2_p0;
            OP_SLL:  result_p0 = src1_p0 << shamt_p0;
            OP_SLT:  result_p0 = {{(DATA_LEN-1){1'b0}}, less_p0};
            OP_SLTU: result_p0 = {{(DATA_LEN-1){1'b0}}, less_p0};
            OP_XOR:  result_p0 = src1_p0 ^ src2_p0;
            OP_SRL:  result_p0 = src1_p0 >> shamt_p0;
            OP_SRA:  result_p0 = sra_s_p0;
            OP_OR:   result_p0 = src1_p0 | src2_p0;
            OP_AND:  result_p0 = src1_p0 & src2_p0;
            default: result_p0 = '0;
        endcase
        zero_p0 = (result_p0 == '0);
        // Decode pairs the branch type with the matching compare op; not checked here.
        case (branch_type_i)
            BR_BEQ:  branch_p0 = zero_p0;
            BR_BNE:  branch_p0 = ~zero_p0;
            BR_BLT:  branch_p0 = less_p0;
            BR_BGE:  branch_p0 = ~less_p0;
            BR_BLTU: branch_p0 = less_p0;
            BR_BGEU: branch_p0 = ~less_p0;
            default: branch_p0 = 1'b0;
        endcase
    end

    // ---- stage p0 -> p1: output register ----
    // Capture on valid; idle cycles hold the result but never re-issue a branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            result_p1 <= '0;
            zero_p1   <= 1'b0;
            less_p1   <= 1'b0;
            branch_p1 <= 1'b0;
        end else if (in_valid) begin
            vld_p1    <= 1'b1;
            result_p1 <= result_p0;
            zero_p1   <= zero_p0;
            less_p1   <= less_p0;
            branch_p1 <= branch_p0;
        end else begin
            vld_p1    <= 1'b0;
            branch_p1 <= 1'b0;
        end
    end

    assign out_valid        = vld_p1;
    assign alu_result_o     = result_p1;
    assign alu_zero_o       = zero_p1;
    assign alu_less_o       = less_p1;
    assign branch_request_o = branch_p1;

endmodule

// File: tb/tb_exe_alu_unit.sv
// Directed testbench for exe_alu_unit with hand-computed expected values.
module tb_exe_alu_unit;

    localparam int DATA_LEN = 32;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3,
                           SLTU = 4'd4, XOR = 4'd5, SRL = 4'd6, SRA = 4'd7,
                           OR = 4'd8, AND = 4'd9, BAD = 4'd12;
    // alu_sel = {src2 key, src1 key}
    localparam logic [3:0] SEL_R1_R2  = 4'b0101;
    localparam logic [3:0] SEL_R1_IMM = 4'b1001;
    localparam logic [3:0] SEL_PC_4   = 4'b1110;
    localparam logic [3:0] SEL_DF_R2  = 4'b0111;
    localparam logic [3:0] SEL_Z_Z    = 4'b0000;
    localparam logic [2:0] BR_NONE = 3'b000, BEQ = 3'b001, BNE = 3'b010,
                           BLT = 3'b011, BGE = 3'b100, BLTU = 3'b101,
                           BGEU = 3'b110, BR_DEF = 3'b111;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic [DATA_LEN-1:0] reg1_i;
    logic [DATA_LEN-1:0] reg2_i;
    logic [DATA_LEN-1:0] pc_i;
    logic [DATA_LEN-1:0] imm_i;
    logic [3:0]          alu_control;
    logic [3:0]          alu_sel;
    logic [2:0]          branch_type_i;
    logic                out_valid;
    logic [DATA_LEN-1:0] alu_result_o;
    logic                alu_zero_o;
    logic                alu_less_o;
    logic                branch_request_o;

    int errors = 0;
    int checks = 0;

    exe_alu_unit #(.DATA_LEN(DATA_LEN)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .reg1_i           (reg1_i),
        .reg2_i           (reg2_i),
        .pc_i             (pc_i),
        .imm_i            (imm_i),
        .alu_control      (alu_control),
        .alu_sel          (alu_sel),
        .branch_type_i    (branch_type_i),
        .out_valid        (out_valid),
        .alu_result_o     (alu_result_o),
        .alu_zero_o       (alu_zero_o),
        .alu_less_o       (alu_less_o),
        .branch_request_o (branch_request_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one valid operation, then sample one cycle later, away from the edge.
    task automatic issue(input logic [3:0] ctl, input logic [3:0] sel, input logic [2:0] bt,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] pc, input logic [31:0] imm);
        in_valid      = 1'b1;
        alu_control   = ctl;
        alu_sel       = sel;
        branch_type_i = bt;
        reg1_i        = r1;
        reg2_i        = r2;
        pc_i          = pc;
        imm_i         = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        reg1_i   = $urandom;
        reg2_i   = $urandom;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with random valid traffic: every output stays at zero.
        rst_n         = 1'b0;
        in_valid      = 1'b1;
        reg1_i        = $urandom;
        reg2_i        = $urandom;
        pc_i          = $urandom;
        imm_i         = $urandom;
        alu_control   = ADD;
        alu_sel       = SEL_R1_R2;
        branch_type_i = BNE;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_result", alu_result_o, 32'd0);
        check("rst_zero",   {31'd0, alu_zero_o}, 32'd0);
        check("rst_less",   {31'd0, alu_less_o}, 32'd0);
        check("rst_branch", {31'd0, branch_request_o}, 32'd0);

        // Release reset with an op pending: first edge produces it.
        reg1_i = 32'd10;
        reg2_i = 32'd7;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid",  {31'd0, out_valid}, 32'd1);
        check("post_rst_result", alu_result_o, 32'd17);
        check("post_rst_branch", {31'd0, branch_request_o}, 32'd1);

        // ADD: JAL link and wrap-around.
        issue(ADD, SEL_PC_4, BR_NONE, 32'h0, 32'h0, 32'h8000_0000, 32'h0);
        check("jal_link", alu_result_o, 32'h8000_0004);
        issue(ADD, SEL_R1_R2, BR_NONE, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        check("add_wrap", alu_result_o, 32'h0);
        check("add_wrap_zero", {31'd0, alu_zero_o}, 32'd1);
        issue(SUB, SEL_R1_R2, BR_NONE, 32'd0, 32'd1, 32'h0, 32'h0);
        check("sub_wrap", alu_result_o, 32'hFFFF_FFFF);
        check("sub_wrap_zero", {31'd0, alu_zero_o}, 32'd0);

        // Shifts use only the low five bits of the amount (0x21 -> 1).
        issue(SRA, SEL_R1_IMM, BR_NONE, 32'h8000_0000, 32'h0, 32'h0, 32'h21);
        check("sra", alu_result_o, 32'hC000_0000);
        issue(SRL, SEL_R1_IMM, BR_NONE, 32'h8000_0000, 32'h0, 32'h0, 32'h21);
        check("srl", alu_result_o, 32'h4000_0000);
        issue(SLL, SEL_R1_IMM, BR_NONE, 32'h8000_0000, 32'h0, 32'h0, 32'h21);
        check("sll", alu_result_o, 32'h0);
        check("sll_zero", {31'd0, alu_zero_o}, 32'd1);
        issue(SLL, SEL_R1_IMM, BR_NONE, 32'h0000_0003, 32'h0, 32'h0, 32'h24);
        check("sll_by4", alu_result_o, 32'h0000_0030);

        // Signed vs unsigned compare and the matching branches.
        issue(SLT, SEL_R1_R2, BLT, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        check("slt_result", alu_result_o, 32'd1);
        check("slt_less",   {31'd0, alu_less_o}, 32'd1);
        check("blt_taken",  {31'd0, branch_request_o}, 32'd1);
        issue(SLT, SEL_R1_R2, BGE, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        check("bge_not",    {31'd0, branch_request_o}, 32'd0);
        issue(SLTU, SEL_R1_R2, BGEU, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        check("sltu_result", alu_result_o, 32'd0);
        check("sltu_less",   {31'd0, alu_less_o}, 32'd0);
        check("bgeu_taken",  {31'd0, branch_request_o}, 32'd1);
        issue(SLTU, SEL_R1_R2, BLTU, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0);
        check("sltu2_result", alu_result_o, 32'd1);
        check("bltu_taken",   {31'd0, branch_request_o}, 32'd1);

        // Equality branches on SUB.
        issue(SUB, SEL_R1_R2, BEQ, 32'h1234, 32'h1234, 32'h0, 32'h0);
        check("beq_zero",  {31'd0, alu_zero_o}, 32'd1);
        check("beq_taken", {31'd0, branch_request_o}, 32'd1);
        issue(SUB, SEL_R1_R2, BNE, 32'h1234, 32'h1234, 32'h0, 32'h0);
        check("bne_not", {31'd0, branch_request_o}, 32'd0);
        issue(SUB, SEL_R1_R2, BNE, 32'h1234, 32'h1235, 32'h0, 32'h0);
        check("bne_taken", {31'd0, branch_request_o}, 32'd1);
        issue(SUB, SEL_R1_R2, BR_DEF, 32'h1234, 32'h1234, 32'h0, 32'h0);
        check("br111_not", {31'd0, branch_request_o}, 32'd0);

        // Mux defaults and unused opcodes.
        issue(ADD, SEL_DF_R2, BR_NONE, 32'hDEAD_BEEF, 32'h1234, 32'h5555_0000, 32'h0);
        check("src1_default", alu_result_o, 32'h1234);
        issue(OR, SEL_Z_Z, BR_NONE, 32'hDEAD_BEEF, 32'h1234, 32'h5555_0000, 32'h77);
        check("both_zero_sel", alu_result_o, 32'h0);
        issue(BAD, SEL_R1_R2, BEQ, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 32'h0);
        check("op12_zero",   alu_result_o, 32'h0);
        check("op12_beq",    {31'd0, branch_request_o}, 32'd1);

        // Valid gating: result holds, branch request drops.
        issue(ADD, SEL_R1_R2, BNE, 32'd2, 32'd3, 32'h0, 32'h0);
        check("gate_result", alu_result_o, 32'd5);
        check("gate_branch", {31'd0, branch_request_o}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            idle();
            check("idle_valid",  {31'd0, out_valid}, 32'd0);
            check("idle_result", alu_result_o, 32'd5);
            check("idle_branch", {31'd0, branch_request_o}, 32'd0);
        end

        // Back-to-back ops give a new result every cycle.
        issue(XOR, SEL_R1_R2, BR_NONE, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 32'h0);
        check("b2b_xor_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_xor", alu_result_o, 32'hF0F0_F0F0);
        issue(OR, SEL_R1_IMM, BR_NONE, 32'h1200_0000, 32'h0, 32'h0, 32'h0000_0034);
        check("b2b_or_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_or", alu_result_o, 32'h1200_0034);
        issue(AND, SEL_R1_R2, BR_NONE, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 32'h0);
        check("b2b_and_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_and", alu_result_o, 32'h0F00_0F00);

        // Mid-stream reset clears outputs without waiting for a clock edge.
        issue(ADD, SEL_R1_R2, BNE, 32'd100, 32'd1, 32'h0, 32'h0);
        check("pre_mid_rst", alu_result_o, 32'd101);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", alu_result_o, 32'd0);
        check("mid_rst_branch", {31'd0, branch_request_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(SUB, SEL_R1_R2, BR_NONE, 32'd9, 32'd4, 32'h0, 32'h0);
        check("after_mid_rst", alu_result_o, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
